// File: rtl/sram_bist_collar_pkg.sv
// Shared widths, BIST op encodings and collar FSM state codes.
package sram_bist_collar_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 9;
  localparam int LOG_D  = 4;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_CHECK  = 2'd2
  } state_t;
endpackage

// File: rtl/sram_bist_collar_core.sv
// 256x4 SRAM core: synchronous write, registered read (old data on a write cycle).
module sram_256x4_core
  import sram_bist_collar_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_dout;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_dout <= '0;
    else          r_dout <= r_mem[i_addr];
  end

  assign o_dout = r_dout;
endmodule

// File: rtl/sram_bist_collar.sv
// BIST-side collar around the 256x4 SRAM; optional fail log enabled by FAIL_LOG_EN.
module sram_bist_collar
  import sram_bist_collar_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Test_Mode,
  input  logic [ADDR_W-1:0] Func_Addr,
  input  logic              Func_WE,
  input  logic [DATA_W-1:0] Func_Din,
  output logic [DATA_W-1:0] Func_Dout,
  input  logic              Bist_Valid,
  output logic              Bist_Ready,
  input  logic              Bist_Op,
  input  logic [ADDR_W-1:0] Bist_Addr,
  input  logic [DATA_W-1:0] Bist_Data,
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic              Rsp_Fail,
  output logic              Fail_Any,
  output logic [CNT_W-1:0]  Fail_Count,
  output logic [ADDR_W-1:0] First_Addr,
  output logic [DATA_W-1:0] First_Syndrome,
`ifdef FAIL_LOG_EN
  input  logic              Log_Pop,
  output logic              Log_Empty,
  output logic [ADDR_W-1:0] Log_Addr,
  output logic [DATA_W-1:0] Log_Syn,
`endif
  input  logic              Clr_Status
);
  state_t            r_state, w_next;
  logic              r_op, r_chk_first;
  logic [ADDR_W-1:0] r_addr, r_first_addr;
  logic [DATA_W-1:0] r_data, r_first_syn;
  logic              r_fail_any;
  logic [CNT_W-1:0]  r_fail_cnt;
  logic              w_sram_we;
  logic [ADDR_W-1:0] w_sram_addr;
  logic [DATA_W-1:0] w_sram_din, w_rdata, w_syn;
  logic              w_accept, w_fail, w_upd;

  sram_256x4_core u_core (
    .i_clk  (Clock),
    .i_rst_n(Reset_n),
    .i_we   (w_sram_we),
    .i_addr (w_sram_addr),
    .i_din  (w_sram_din),
    .o_dout (w_rdata)
  );

  assign w_accept = (r_state == ST_IDLE) && Test_Mode && Bist_Valid;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_WR;
      r_addr      <= '0;
      r_data      <= '0;
      r_chk_first <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_chk_first <= (r_state == ST_ACCESS);
      if (w_accept) begin
        r_op   <= Bist_Op;
        r_addr <= Bist_Addr;
        r_data <= Bist_Data;
      end
    end
  end

  // Outside IDLE the SRAM keeps re-reading r_addr, so the compare stays stable while stalled.
  always_comb begin
    w_next      = r_state;
    Bist_Ready  = 1'b0;
    Rsp_Valid   = 1'b0;
    w_sram_we   = 1'b0;
    w_sram_addr = r_addr;
    w_sram_din  = r_data;
    case (r_state)
      ST_IDLE: begin
        Bist_Ready = Test_Mode;
        if (!Test_Mode) begin
          w_sram_we   = Func_WE;
          w_sram_addr = Func_Addr;
          w_sram_din  = Func_Din;
        end
        if (w_accept) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_sram_we = (r_op == OP_WR);
        w_next    = ST_CHECK;
      end
      ST_CHECK: begin
        Rsp_Valid = 1'b1;
        if (Rsp_Ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_syn    = w_rdata ^ r_data;
  assign w_fail   = Rsp_Valid && (r_op == OP_RC) && (|w_syn);
  assign w_upd    = w_fail && r_chk_first;
  assign Rsp_Fail = w_fail;

  always_ff @(posedge Clock) begin
    if (!Reset_n || Clr_Status) begin
      r_fail_any   <= 1'b0;
      r_fail_cnt   <= '0;
      r_first_addr <= '0;
      r_first_syn  <= '0;
    end else if (w_upd) begin
      r_fail_any <= 1'b1;
      if (!r_fail_any) begin
        r_first_addr <= r_addr;
        r_first_syn  <= w_syn;
      end
      if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
    end
  end

  assign Func_Dout      = w_rdata;
  assign Fail_Any       = r_fail_any;
  assign Fail_Count     = r_fail_cnt;
  assign First_Addr     = r_first_addr;
  assign First_Syndrome = r_first_syn;

`ifdef FAIL_LOG_EN
  localparam int PTR_W = $clog2(LOG_D);
  logic [ADDR_W+DATA_W-1:0] r_log [LOG_D];
  logic [PTR_W:0]           r_wr_ptr, r_rd_ptr;
  logic                     w_full, w_pop, w_push;

  assign Log_Empty = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop     = Log_Pop && !Log_Empty;
  assign w_push    = w_upd && !Clr_Status && (!w_full || w_pop);

  always_ff @(posedge Clock) begin
    if (w_push) r_log[r_wr_ptr[PTR_W-1:0]] <= {r_addr, w_syn};
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n || Clr_Status) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign Log_Addr = r_log[r_rd_ptr[PTR_W-1:0]][ADDR_W+DATA_W-1:DATA_W];
  assign Log_Syn  = r_log[r_rd_ptr[PTR_W-1:0]][DATA_W-1:0];
`endif
endmodule
